// File: rtl/cmd_loader_pkg.sv
// Shared types and constants for the TRS-80 /CMD stream loader.
// States, record kinds, record-type bytes and error codes.
package cmd_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TYPE,
    S_LEN,
    S_ADDR_LO,
    S_ADDR_HI,
    S_DATA,
    S_XLO,
    S_XHI,
    S_SKIP,
    S_DONE,
    S_FLUSH,
    S_EXEC
  } state_t;

  typedef enum logic [1:0] {
    K_LOAD,
    K_XFER,
    K_SKIP
  } kind_t;

  localparam logic [7:0] REC_LOAD = 8'h01;
  localparam logic [7:0] REC_XFER = 8'h02;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_TRUNC = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_TYPE  = 2'd3;

  // Length bytes 0..2 encode 256..258 payload bytes; two are the address.
  function automatic logic [8:0] load_count(input logic [7:0] n);
    if (n < 8'd3) return {1'b0, n} + 9'd254;
    return {1'b0, n} - 9'd2;
  endfunction

endpackage

// File: rtl/cmd_wr_buf.sv
// One-entry valid/ready buffer between the parser and the RAM arbiter.
// A new entry may be loaded in the same cycle the old one drains.
module cmd_wr_buf #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [7:0]    push_data,
  input  logic          ready,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [7:0]    data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      addr  <= push_addr;
      data  <= push_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_stream_loader.sv
// TRS-80 /CMD stream parser: RAM writes with backpressure, relocation,
// transfer-address capture, timed execute pulse and error reporting.
module cmd_stream_loader
  import cmd_loader_pkg::*;
#(
  parameter logic [7:0]  INDEX       = 8'd2,
  parameter int          ADDR_W      = 16,
  parameter int unsigned ADDR_OFFSET = 0,
  parameter int          EXEC_HOLD   = 16,
  parameter bit          STRICT      = 1'b0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              loader_download,
  output logic              loader_wr,
  input  logic              loader_ready,
  output logic [ADDR_W-1:0] loader_addr,
  output logic [7:0]        loader_data,
  output logic [15:0]       execute_addr,
  output logic              execute_enable,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [7:0]        blocks_loaded
);

  localparam int HW = (EXEC_HOLD > 1) ? $clog2(EXEC_HOLD) : 1;

  state_t      state, st_n;
  kind_t       kind, kind_n;
  logic [8:0]  cnt, cnt_n;
  logic [15:0] ptr, ptr_n;
  logic [7:0]  xlo, xlo_n;
  logic [15:0] xaddr_n;
  logic        xfer, xfer_n;
  logic [1:0]  err_n;
  logic [7:0]  blk_n;
  logic [HW-1:0] hold, hold_n;
  logic        dl, dl_q, rise;
  logic        stall, take, push;
  logic        set_err;
  logic [1:0]  err_val;
  logic [7:0]  b;
  logic [ADDR_W-1:0] wr_addr;

  assign dl    = ioctl_download & (ioctl_index == INDEX);
  assign rise  = dl & ~dl_q;
  assign stall = loader_wr & ~loader_ready & (state == S_DATA);
  assign take  = dl & ioctl_wr & ~stall;
  assign b     = ioctl_dout;

  assign ioctl_wait      = stall;
  assign loader_download = dl_q | loader_wr;
  assign execute_enable  = (state == S_EXEC);
  assign error           = |err_code;
  assign wr_addr = ADDR_W'(ADDR_OFFSET) + ADDR_W'(ptr);

  cmd_wr_buf #(
    .AW(ADDR_W)
  ) u_buf (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .push      (push),
    .push_addr (wr_addr),
    .push_data (b),
    .ready     (loader_ready),
    .valid     (loader_wr),
    .addr      (loader_addr),
    .data      (loader_data)
  );

  always_comb begin
    st_n    = state;
    kind_n  = kind;
    cnt_n   = cnt;
    ptr_n   = ptr;
    xlo_n   = xlo;
    xaddr_n = execute_addr;
    xfer_n  = xfer;
    err_n   = err_code;
    blk_n   = blocks_loaded;
    hold_n  = hold;
    push    = 1'b0;
    set_err = 1'b0;
    err_val = ERR_NONE;

    case (state)
      S_TYPE: if (take) begin
        st_n = S_LEN;
        case (b)
          REC_LOAD: kind_n = K_LOAD;
          REC_XFER: kind_n = K_XFER;
          default: begin
            kind_n = K_SKIP;
            if (STRICT) begin
              set_err = 1'b1;
              err_val = ERR_TYPE;
              st_n    = S_DONE;
            end
          end
        endcase
      end
      S_LEN: if (take) begin
        unique case (kind)
          K_LOAD: begin
            cnt_n = load_count(b);
            st_n  = S_ADDR_LO;
          end
          K_XFER: begin
            if (b == 8'd2) begin
              st_n = S_XLO;
            end else begin
              set_err = 1'b1;
              err_val = ERR_LEN;
              st_n    = S_DONE;
            end
          end
          default: begin
            cnt_n = (b == 8'd0) ? 9'd256 : {1'b0, b};
            st_n  = S_SKIP;
          end
        endcase
      end
      S_ADDR_LO: if (take) begin
        ptr_n[7:0] = b;
        st_n       = S_ADDR_HI;
      end
      S_ADDR_HI: if (take) begin
        ptr_n[15:8] = b;
        st_n = (cnt == 9'd0) ? S_TYPE : S_DATA;
      end
      S_DATA: if (take) begin
        push  = 1'b1;
        ptr_n = ptr + 16'd1;
        cnt_n = cnt - 9'd1;
        if (cnt == 9'd1) begin
          st_n = S_TYPE;
          if (blocks_loaded != 8'hFF) blk_n = blocks_loaded + 8'd1;
        end
      end
      S_XLO: if (take) begin
        xlo_n = b;
        st_n  = S_XHI;
      end
      S_XHI: if (take) begin
        xaddr_n = {b, xlo};
        xfer_n  = 1'b1;
        st_n    = S_DONE;
      end
      S_SKIP: if (take) begin
        cnt_n = cnt - 9'd1;
        if (cnt == 9'd1) st_n = S_TYPE;
      end
      S_FLUSH: if (!loader_wr) begin
        hold_n = HW'(EXEC_HOLD - 1);
        st_n   = (xfer && !error) ? S_EXEC : S_IDLE;
      end
      S_EXEC: begin
        if (hold == '0) st_n = S_IDLE;
        else hold_n = hold - 1'b1;
      end
      default: ;
    endcase

    // take is gated by dl, so nothing above has fired when dl is low
    if (!dl && state inside {[S_TYPE:S_DONE]}) begin
      st_n = S_FLUSH;
      if (state != S_TYPE && state != S_DONE) begin
        set_err = 1'b1;
        err_val = ERR_TRUNC;
      end
    end

    if (set_err && !error) err_n = err_val;

    if (rise) begin
      st_n   = S_TYPE;
      err_n  = ERR_NONE;
      blk_n  = 8'd0;
      xfer_n = 1'b0;
      push   = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= st_n;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q          <= 1'b0;
      kind          <= K_SKIP;
      cnt           <= '0;
      ptr           <= '0;
      xlo           <= '0;
      execute_addr  <= '0;
      xfer          <= 1'b0;
      err_code      <= ERR_NONE;
      blocks_loaded <= '0;
      hold          <= '0;
    end else begin
      dl_q          <= dl;
      kind          <= kind_n;
      cnt           <= cnt_n;
      ptr           <= ptr_n;
      xlo           <= xlo_n;
      execute_addr  <= xaddr_n;
      xfer          <= xfer_n;
      err_code      <= err_n;
      blocks_loaded <= blk_n;
      hold          <= hold_n;
    end
  end

endmodule

// File: tb/tb_cmd_stream_loader.sv
// Directed bench: default loader (index 2) and a relocated strict
// loader (index 3, 17-bit, offset 0x10000) share one byte source.
module tb_cmd_stream_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        download = 1'b0;
  logic [7:0]  index = 8'd0;
  logic        wr = 1'b0;
  logic [7:0]  dout = 8'd0;
  logic        ready = 1'b1;

  logic        wait0, dl0, wr0, exec0, err0;
  logic [15:0] addr0, xaddr0;
  logic [7:0]  data0, blk0;
  logic [1:0]  code0;

  logic        wait1, dl1, wr1, exec1, err1;
  logic [16:0] addr1;
  logic [15:0] xaddr1;
  logic [7:0]  data1, blk1;
  logic [1:0]  code1;

  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  wr_cnt = 0;
  int  exec_cnt = 0;
  int  wait_cnt = 0;
  int  stall_n = 0;
  logic wait_sel;

  always #5 clk = ~clk;

  assign wait_sel = (index == 8'd3) ? wait1 : wait0;

  cmd_stream_loader u_dut0 (
    .clk_sys         (clk),
    .reset_n         (reset_n),
    .ioctl_download  (download),
    .ioctl_index     (index),
    .ioctl_wr        (wr),
    .ioctl_dout      (dout),
    .ioctl_wait      (wait0),
    .loader_download (dl0),
    .loader_wr       (wr0),
    .loader_ready    (ready),
    .loader_addr     (addr0),
    .loader_data     (data0),
    .execute_addr    (xaddr0),
    .execute_enable  (exec0),
    .error           (err0),
    .err_code        (code0),
    .blocks_loaded   (blk0)
  );

  cmd_stream_loader #(
    .INDEX       (8'd3),
    .ADDR_W      (17),
    .ADDR_OFFSET (32'h10000),
    .STRICT      (1'b1)
  ) u_dut1 (
    .clk_sys         (clk),
    .reset_n         (reset_n),
    .ioctl_download  (download),
    .ioctl_index     (index),
    .ioctl_wr        (wr),
    .ioctl_dout      (dout),
    .ioctl_wait      (wait1),
    .loader_download (dl1),
    .loader_wr       (wr1),
    .loader_ready    (ready),
    .loader_addr     (addr1),
    .loader_data     (data1),
    .execute_addr    (xaddr1),
    .execute_enable  (exec1),
    .error           (err1),
    .err_code        (code1),
    .blocks_loaded   (blk1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input logic [16:0] a, input logic [7:0] d);
    wr_t e;
    wr_cnt++;
    if (exp_q.size() == 0) begin
      chk("unexpected_write", {7'd0, a, d}, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("wr_addr", {15'd0, a}, {15'd0, e.a});
      chk("wr_data", {24'd0, d}, {24'd0, e.d});
    end
  endtask

  // Inputs change at posedge+1, so negedge shows what the next edge takes.
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr0 && ready) pop_chk({1'b0, addr0}, data0);
      if (wr1 && ready) pop_chk(addr1, data1);
      if (exec0 || exec1) exec_cnt++;
      if (wait_sel) wait_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic w;
    int   guard;
    dout  = b;
    wr    = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      w = wait_sel;
      @(posedge clk);
      #1;
      if (stall_n > 0) begin
        stall_n--;
        ready = (stall_n == 0);
      end
      guard++;
      if (guard > 50) begin
        chk("wait_timeout", 32'd1, 32'd0);
        w = 1'b0;
      end
    end while (w);
  endtask

  task automatic send_data(input logic [16:0] a, input logic [7:0] b);
    wr_t e;
    e.a = a;
    e.d = b;
    exp_q.push_back(e);
    send(b);
  endtask

  task automatic begin_dl(input logic [7:0] idx);
    wr_cnt   = 0;
    exec_cnt = 0;
    wait_cnt = 0;
    index    = idx;
    download = 1'b1;
    tick(2);
  endtask

  task automatic end_dl();
    wr       = 1'b0;
    download = 1'b0;
    tick(40);
  endtask

  task automatic hdr_load7000();
    send(8'h01);
    send(8'h05);
    send(8'h00);
    send(8'h70);
  endtask

  task automatic xfer7000();
    send(8'h02);
    send(8'h02);
    send(8'h00);
    send(8'h70);
  endtask

  task automatic expect_t1(input string t);
    chk({t, "_writes"}, wr_cnt, 3);
    chk({t, "_qempty"}, exp_q.size(), 0);
    chk({t, "_blocks"}, {24'd0, blk0}, 1);
    chk({t, "_xaddr"}, {16'd0, xaddr0}, 32'h7000);
    chk({t, "_exec"}, exec_cnt, 16);
    chk({t, "_err"}, {29'd0, err0, code0}, 0);
  endtask

  initial begin
    tick(3);
    chk("reset_out0", {wait0, dl0, wr0, exec0, err0, code0, blk0,
                       xaddr0[7:0]}, 0);
    chk("reset_out1", {wait1, dl1, wr1, exec1, err1, code1, blk1,
                       xaddr1[7:0]}, 0);
    reset_n = 1'b1;
    tick(2);

    // basic load + transfer
    begin_dl(8'd2);
    hdr_load7000();
    send_data(17'h07000, 8'hAA);
    send_data(17'h07001, 8'hBB);
    send_data(17'h07002, 8'hCC);
    xfer7000();
    end_dl();
    expect_t1("t1");

    // arbiter stall on the second data byte
    begin_dl(8'd2);
    hdr_load7000();
    send_data(17'h07000, 8'hAA);
    ready   = 1'b0;
    stall_n = 5;
    send_data(17'h07001, 8'hBB);
    send_data(17'h07002, 8'hCC);
    xfer7000();
    end_dl();
    chk("t2_wait", wait_cnt, 5);
    expect_t1("t2");

    // 254-byte block wrapping at 0xFFFF, relocated by 0x10000
    begin_dl(8'd3);
    send(8'h01);
    send(8'h00);
    send(8'hFF);
    send(8'hFF);
    for (int i = 0; i < 254; i++) begin
      logic [15:0] p;
      p = 16'hFFFF + 16'(i);
      send_data({1'b1, p}, 8'(i * 7 + 3));
    end
    end_dl();
    chk("t3_writes", wr_cnt, 254);
    chk("t3_qempty", exp_q.size(), 0);
    chk("t3_blocks", {24'd0, blk1}, 1);
    chk("t3_err", {29'd0, err1, code1}, 0);
    chk("t3_exec", exec_cnt, 0);

    // unknown record skipped on the lenient loader
    begin_dl(8'd2);
    send(8'h05);
    send(8'h03);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    hdr_load7000();
    send_data(17'h07000, 8'hAA);
    send_data(17'h07001, 8'hBB);
    send_data(17'h07002, 8'hCC);
    xfer7000();
    end_dl();
    expect_t1("t4");

    // unknown record is fatal on the strict loader
    begin_dl(8'd3);
    send(8'h05);
    send(8'h03);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    hdr_load7000();
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    xfer7000();
    end_dl();
    chk("t4s_code", {29'd0, err1, code1}, 32'h7);
    chk("t4s_writes", wr_cnt, 0);
    chk("t4s_blocks", {24'd0, blk1}, 0);
    chk("t4s_exec", exec_cnt, 0);

    // truncated mid-block
    begin_dl(8'd2);
    hdr_load7000();
    send_data(17'h07000, 8'hAA);
    end_dl();
    chk("t5_code", {29'd0, err0, code0}, 32'h5);
    chk("t5_writes", wr_cnt, 1);
    chk("t5_qempty", exp_q.size(), 0);
    chk("t5_exec", exec_cnt, 0);
    chk("t5_blocks", {24'd0, blk0}, 0);

    // bad transfer length; later fault must not overwrite it
    begin_dl(8'd2);
    send(8'h02);
    send(8'h03);
    send(8'h00);
    send(8'h70);
    send(8'h01);
    end_dl();
    chk("t6_code", {29'd0, err0, code0}, 32'h6);
    chk("t6_exec", exec_cnt, 0);
    begin_dl(8'd2);
    chk("t6_clear", {29'd0, err0, code0}, 0);
    chk("t6_dlout", {31'd0, dl0}, 1);
    end_dl();
    chk("t6_after", {29'd0, err0, code0}, 0);
    chk("t6_exec2", exec_cnt, 0);
    chk("t6_idle", {31'd0, dl0}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
